// File: rtl/target_frame_parser.sv
// -----------------------------------------------------------------------------
// target_frame_parser
//
// Assembles 11-byte command frames from the UART byte stream and publishes
// the four 16-bit flight targets when the header and additive checksum match.
//
// Frame: HDR0 HDR1 P0 P1 P2 P3 P4 P5 P6 P7 CS, where CS = (P0+...+P7) mod 256.
// Payload is big-endian: height={P0,P1}, pitch={P2,P3}, roll={P4,P5},
// yaw={P6,P7}.
//
// A valid frame is first copied into a shadow register. The shadow is then
// published to target_* when update_hold is low. A frame that completes
// while update_hold is high stays pending until hold is released. If a newer
// valid frame arrives first, it replaces the pending one.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active-HIGH (1 = in reset)
//   rx_data[7:0]   received byte, qualified by rx_valid
//   rx_valid       one-cycle strobe per received byte
//   update_hold    1 = controller is reading targets; defer publication
//   target_renew   one-cycle pulse; target_* were updated this cycle
//   target_height  height target
//   target_pitch   pitch target (two's complement)
//   target_roll    roll target (two's complement)
//   target_yaw     yaw target (two's complement)
//   frame_err      one-cycle pulse on checksum failure or inter-byte timeout
//   err_cnt[7:0]   saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module target_frame_parser #(
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter logic [7:0]  HDR0        = 8'hAA,
    parameter logic [7:0]  HDR1        = 8'h55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        update_hold,
    output logic        target_renew,
    output logic [15:0] target_height,
    output logic [15:0] target_pitch,
    output logic [15:0] target_roll,
    output logic [15:0] target_yaw,
    output logic        frame_err,
    output logic [7:0]  err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        WAIT_H0,
        WAIT_H1,
        PAYLOAD,
        CHECK
    } state_t;

    state_t         state;
    logic [2:0]     idx;
    logic [7:0]     sum;
    logic [63:0]    pay_sr;    // P0 ends up in [63:56], P7 in [7:0]
    logic [63:0]    shadow;
    logic           pending;
    logic [TW-1:0]  tmo_cnt;

    logic           timeout_hit;
    state_t         byte_st;
    logic           cs_ok;
    logic           cs_bad;
    logic           err_now;

    // The timeout takes priority over a byte that arrives on the same edge.
    // That byte is then interpreted as if the parser were already idle.
    always_comb begin
        timeout_hit = (state != WAIT_H0) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
        byte_st     = timeout_hit ? WAIT_H0 : state;
        cs_ok       = rx_valid && (byte_st == CHECK) && (rx_data == sum);
        cs_bad      = rx_valid && (byte_st == CHECK) && (rx_data != sum);
        err_now     = timeout_hit || cs_bad;
    end

    // NOTE: rst_n is active-high here. The sensitivity list uses posedge,
    // and the reset branch is taken when rst_n == 1.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state         <= WAIT_H0;
            idx           <= '0;
            sum           <= '0;
            pay_sr        <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            tmo_cnt       <= '0;
            target_renew  <= 1'b0;
            target_height <= '0;
            target_pitch  <= '0;
            target_roll   <= '0;
            target_yaw    <= '0;
            frame_err     <= 1'b0;
            err_cnt       <= '0;
        end else begin
            // NOTE: every register here uses non-blocking assignments. Later
            // statements in this block therefore see the pre-edge values,
            // and a later assignment overrides an earlier default.
            target_renew <= 1'b0;
            frame_err    <= err_now;

            // Count idle cycles inside a frame.
            if (rx_valid || (state == WAIT_H0) || timeout_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (timeout_hit)
                state <= WAIT_H0;

            if (rx_valid) begin
                case (byte_st)
                    WAIT_H0: begin
                        state <= (rx_data == HDR0) ? WAIT_H1 : WAIT_H0;
                    end
                    WAIT_H1: begin
                        if (rx_data == HDR1) begin
                            state <= PAYLOAD;
                            idx   <= '0;
                            sum   <= '0;
                        end else if (rx_data == HDR0) begin
                            state <= WAIT_H1;   // resync on a repeated HDR0
                        end else begin
                            state <= WAIT_H0;
                        end
                    end
                    PAYLOAD: begin
                        // Header values are ordinary data inside the payload.
                        pay_sr <= {pay_sr[55:0], rx_data};
                        sum    <= sum + rx_data;
                        idx    <= idx + 3'd1;
                        if (idx == 3'd7)
                            state <= CHECK;
                    end
                    CHECK: begin
                        state <= WAIT_H0;
                    end
                    default: state <= WAIT_H0;
                endcase
            end

            // A frame completing this edge is published directly when hold
            // is low, giving a single renew. It also supersedes any older
            // pending frame.
            if (cs_ok) begin
                shadow <= pay_sr;
                if (!update_hold) begin
                    target_height <= pay_sr[63:48];
                    target_pitch  <= pay_sr[47:32];
                    target_roll   <= pay_sr[31:16];
                    target_yaw    <= pay_sr[15:0];
                    target_renew  <= 1'b1;
                    pending       <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (pending && !update_hold) begin
                target_height <= shadow[63:48];
                target_pitch  <= shadow[47:32];
                target_roll   <= shadow[31:16];
                target_yaw    <= shadow[15:0];
                target_renew  <= 1'b1;
                pending       <= 1'b0;
            end

            if (err_now && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_target_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_target_frame_parser
//
// Directed and randomized checks for target_frame_parser. The DUT is built
// with a short timeout so that the timeout path can be exercised quickly.
// Expected values come from how each frame was constructed (valid or corrupt
// checksum, payload contents) plus a running error count.
// -----------------------------------------------------------------------------
module tb_target_frame_parser;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        update_hold;
    logic        target_renew;
    logic [15:0] target_height;
    logic [15:0] target_pitch;
    logic [15:0] target_roll;
    logic [15:0] target_yaw;
    logic        frame_err;
    logic [7:0]  err_cnt;

    target_frame_parser #(
        .TIMEOUT_CYC (TMO),
        .HDR0        (8'hAA),
        .HDR1        (8'h55)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .update_hold   (update_hold),
        .target_renew  (target_renew),
        .target_height (target_height),
        .target_pitch  (target_pitch),
        .target_roll   (target_roll),
        .target_yaw    (target_yaw),
        .frame_err     (frame_err),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;

    logic [63:0] cur;   // payload currently expected on target_*

    localparam logic [63:0] F1 = 64'h0064_012C_FF38_000A;   // CS D2
    localparam logic [63:0] F2 = 64'h00C8_012C_FF38_000A;   // CS 36

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sum8(input logic [63:0] pl);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < 8; i++) s = s + pl[8*i +: 8];
        return s;
    endfunction

    function automatic int sat_err(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    // Inputs are driven on the falling edge. After the call returns, the
    // registered response to the byte is visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_body(input logic [63:0] pl, input int gap);
        send_byte(8'hAA);
        repeat (gap) @(negedge clk);
        send_byte(8'h55);
        for (int i = 7; i >= 0; i--) begin
            repeat (gap) @(negedge clk);
            send_byte(pl[8*i +: 8]);
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [63:0] pl, input logic [7:0] cs, input int gap);
        send_body(pl, gap);
        send_byte(cs);
    endtask

    task automatic check_targets(input string tag, input logic [63:0] exp);
        check({tag, ".height"}, {16'h0, target_height}, {16'h0, exp[63:48]});
        check({tag, ".pitch"},  {16'h0, target_pitch},  {16'h0, exp[47:32]});
        check({tag, ".roll"},   {16'h0, target_roll},   {16'h0, exp[31:16]});
        check({tag, ".yaw"},    {16'h0, target_yaw},    {16'h0, exp[15:0]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pl;
        logic [7:0]  cs;
        bit          good;
        int          nj;
        logic [7:0]  jb;

        // ---------------- reset state ----------------
        rst_n       = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        update_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.renew", {31'h0, target_renew}, 32'h0);
        check("rst.err",   {31'h0, frame_err}, 32'h0);
        check("rst.cnt",   {24'h0, err_cnt}, 32'h0);
        check_targets("rst", 64'h0);
        rst_n = 1'b0;
        cur   = 64'h0;

        // ---------------- valid frame ----------------
        send_frame(F1, 8'hD2, 0);
        check("valid.renew", {31'h0, target_renew}, 32'h1);
        check("valid.err",   {31'h0, frame_err}, 32'h0);
        check_targets("valid", F1);
        cur = F1;
        @(negedge clk);
        check("valid.renew_once", {31'h0, target_renew}, 32'h0);

        // ---------------- bad checksum ----------------
        send_frame(F1, 8'hD3, 0);
        exp_err++;
        check("badcs.err",   {31'h0, frame_err}, 32'h1);
        check("badcs.renew", {31'h0, target_renew}, 32'h0);
        check("badcs.cnt",   {24'h0, err_cnt}, sat_err(exp_err));
        check_targets("badcs", cur);
        @(negedge clk);
        check("badcs.err_once", {31'h0, frame_err}, 32'h0);

        // ---------------- hold deferral, latest wins ----------------
        update_hold = 1'b1;
        send_frame(F1, 8'hD2, 0);
        check("hold.renew1", {31'h0, target_renew}, 32'h0);
        send_frame(F2, 8'h36, 1);
        check("hold.renew2", {31'h0, target_renew}, 32'h0);
        check_targets("hold.frozen", cur);
        repeat (3) @(negedge clk);
        check("hold.still", {31'h0, target_renew}, 32'h0);
        update_hold = 1'b0;
        @(negedge clk);
        check("hold.renew", {31'h0, target_renew}, 32'h1);
        check_targets("hold", F2);
        cur = F2;
        @(negedge clk);
        check("hold.renew_once", {31'h0, target_renew}, 32'h0);
        repeat (3) @(negedge clk);
        check("hold.no_second", {31'h0, target_renew}, 32'h0);

        // ---------------- resync on repeated header ----------------
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
        for (int i = 7; i >= 0; i--) send_byte(F1[8*i +: 8]);
        send_byte(8'hD2);
        check("resync.renew", {31'h0, target_renew}, 32'h1);
        check_targets("resync", F1);
        cur = F1;

        // ---------------- renew and frame_err on the same cycle ----------------
        update_hold = 1'b1;
        send_frame(F2, 8'h36, 0);            // held as pending
        send_body(F1, 0);
        @(negedge clk);
        rx_data     = 8'h00;                 // wrong CS for F1
        rx_valid    = 1'b1;
        update_hold = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        exp_err++;
        check("both.renew", {31'h0, target_renew}, 32'h1);
        check("both.err",   {31'h0, frame_err}, 32'h1);
        check("both.cnt",   {24'h0, err_cnt}, sat_err(exp_err));
        check_targets("both", F2);
        cur = F2;

        // ---------------- inter-byte timeout ----------------
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h64);
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            check("tmo.early", {31'h0, frame_err}, 32'h0);
        end
        @(negedge clk);
        exp_err++;
        check("tmo.err", {31'h0, frame_err}, 32'h1);
        check("tmo.cnt", {24'h0, err_cnt}, sat_err(exp_err));
        repeat (2 * TMO) @(negedge clk);     // idle parser must not time out again
        check("tmo.idle_cnt", {24'h0, err_cnt}, sat_err(exp_err));
        send_frame(F1, 8'hD2, 0);
        check("tmo.after_renew", {31'h0, target_renew}, 32'h1);
        check_targets("tmo.after", F1);
        cur = F1;

        // ---------------- randomized frames with junk and gaps ----------------
        for (int f = 0; f < 60; f++) begin
            nj = $urandom_range(0, 3);
            for (int j = 0; j < nj; j++) begin
                jb = 8'($urandom);
                if (jb == 8'hAA) jb = 8'h00;
                send_byte(jb);
            end
            pl   = {$urandom, $urandom};
            good = ($urandom_range(0, 9) < 6);
            cs   = good ? sum8(pl) : sum8(pl) + 8'($urandom_range(1, 255));
            send_frame(pl, cs, $urandom_range(0, 8));
            if (good) cur = pl;
            else      exp_err++;
            check("rnd.renew", {31'h0, target_renew}, {31'h0, good});
            check("rnd.err",   {31'h0, frame_err}, {31'h0, !good});
            check("rnd.cnt",   {24'h0, err_cnt}, sat_err(exp_err));
            check_targets("rnd", cur);
        end

        // ---------------- reset mid-payload ----------------
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst.renew", {31'h0, target_renew}, 32'h0);
        check("mrst.err",   {31'h0, frame_err}, 32'h0);
        check("mrst.cnt",   {24'h0, err_cnt}, 32'h0);
        check_targets("mrst", 64'h0);
        rst_n   = 1'b0;
        exp_err = 0;
        cur     = 64'h0;
        // The remainder of the interrupted frame is ignored.
        for (int b = 3; b <= 8; b++) send_byte(8'(b));
        send_byte(8'h24);
        check("mrst.tail_renew", {31'h0, target_renew}, 32'h0);
        check("mrst.tail_err",   {31'h0, frame_err}, 32'h0);

        // ---------------- err_cnt saturation ----------------
        for (int k = 0; k < 300; k++) begin
            send_frame(F2, 8'h37, 0);
            exp_err++;
            check("sat.err", {31'h0, frame_err}, 32'h1);
            check("sat.cnt", {24'h0, err_cnt}, sat_err(exp_err));
        end
        check("sat.final", {24'h0, err_cnt}, 32'd255);
        check_targets("sat", cur);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_frame_parser.md
Name: target_frame_parser

Overview:
Byte-level command frame parser between the UART byte receiver (async_receiver) and the flight-control state machine. It assembles 11-byte command frames and validates the header and an additive checksum. Valid frames are published as four 16-bit targets (height, pitch, roll, yaw) with a one-cycle target_renew strobe. The controller asserts update_hold while it reads the target registers, and the parser defers publication until hold is released, so targets never change mid-computation.

Parameters:
TIMEOUT_CYC, 500000, idle cycles allowed between bytes inside a frame (10 ms at 50 MHz)
HDR0, 8'hAA, first header byte
HDR1, 8'h55, second header byte

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  reset; asynchronous, active-high (asserted = 1)
rx_data  input  8  received byte, valid only with rx_valid
rx_valid  input  1  one-cycle strobe per received byte
update_hold  input  1  1 = controller busy; defer target publication
target_renew  output  1  one-cycle pulse; target_* updated this cycle
target_height  output  16  height target
target_pitch  output  16  pitch target (two's complement)
target_roll  output  16  roll target (two's complement)
target_yaw  output  16  yaw target (two's complement)
frame_err  output  1  one-cycle pulse on checksum fail or timeout
err_cnt  output  8  saturating count of frame_err pulses

Behaviour:
- Reset (rst_n=1, async): all outputs 0, state WAIT_H0, pending flag 0, shadow registers 0, timeout counter 0.
- Frame format: HDR0, HDR1, P0..P7, CS. Payload is big-endian: height={P0,P1}, pitch={P2,P3}, roll={P4,P5}, yaw={P6,P7}. CS = (P0+...+P7) mod 256.
- States: WAIT_H0, WAIT_H1, PAYLOAD (3-bit index 0..7), CHECK.
  - WAIT_H0: byte==HDR0 -> WAIT_H1; any other byte -> stay.
  - WAIT_H1: byte==HDR1 -> PAYLOAD with index=0 and sum=0; byte==HDR0 -> stay in WAIT_H1 (resync); any other byte -> WAIT_H0.
  - PAYLOAD: store byte at index and add it to the 8-bit sum (wraps). After index 7 -> CHECK.
  - CHECK: byte==sum -> load shadow registers, set pending, go to WAIT_H0. Mismatch -> frame_err pulse, shadow unchanged, go to WAIT_H0.
- Header bytes are not rescanned inside PAYLOAD or CHECK; 0xAA is legal payload.
- Timeout:
  - Counter clears on every rx_valid and whenever state is WAIT_H0.
  - Counter increments in every other state.
  - On reaching TIMEOUT_CYC: go to WAIT_H0, frame_err pulse, partial frame discarded.
- Publication:
  - When pending=1 and update_hold=0, then on the next edge: target_* <= shadow, target_renew=1 for exactly one cycle, pending cleared.
  - Latency with hold low: target_renew high on the cycle immediately after the edge that sampled the valid CS byte (shadow load and publication are combined; 1-cycle latency).
  - Hold high: pending is held; publication occurs on the first edge with update_hold=0.
  - A new valid frame completing while pending=1 overwrites shadow (latest wins). Only one renew is issued.
  - Parsing continues regardless of update_hold.
- target_* change only on the cycle target_renew is asserted; otherwise they hold.
- frame_err and target_renew may both assert in the same cycle (pending publish plus a failing frame); both take effect.
- err_cnt increments on each frame_err and saturates at 255; it is cleared only by reset.
- rx_valid arriving on the same edge as timeout expiry: the timeout wins, and that byte is evaluated as in WAIT_H0.
- Reset mid-frame: immediate return to reset values; partial frame and pending data are lost.

Test Plan:
- Valid frame: AA 55 00 64 01 2C FF 38 00 0A D2, hold=0 -> one renew 1 cycle after the CS byte; height=100, pitch=0x012C (300), roll=0xFF38 (-200), yaw=10; frame_err=0.
- Bad checksum: same frame with CS=D3 -> frame_err pulse, err_cnt=1, no renew, targets unchanged.
- Hold deferral: send the valid frame with hold=1, then a second valid frame with height=0x00C8 and CS=36, then drop hold -> exactly one renew, on the first cycle after hold falls; height=200.
- Resync: stream 12 AA AA 55 followed by the valid payload and CS -> frame accepted, height=100.
- Timeout: AA 55 00 64, then idle TIMEOUT_CYC cycles -> frame_err, state WAIT_H0; a following valid frame is accepted normally.
- Reset and saturation: assert rst_n mid-payload -> all outputs 0; then 300 bad-CS frames -> err_cnt=255.
